difftest_commit_checker: RTL and testbench
==========================================

Name: difftest_commit_checker

Overview:
- Simulation-side checker that receives the core's per-cycle commit stream, architectural GPR snapshot and trap event.
- Keeps a shadow integer register file built only from committed writes and compares it against the core's live GPR snapshot on every commit.
- Latches the first divergence and the first trap, and counts commits.
- Sits beside the CPU top under the simulation top, in place of the external difftest helpers.

Parameters:
- XLEN, 32, data/PC/register width.
- NREG, 32, number of architectural integer registers (r0 hardwired zero).
- CNT_W, 64, width of the commit and cycle counters.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  XLEN  retiring PC.
- commit_instr  in  32  retiring instruction word.
- commit_skip  in  1  retiring result is not checkable (MMIO/counter read).
- commit_wen  in  1  retiring instruction writes a GPR.
- commit_wdest  in  5  destination register index.
- commit_wdata  in  XLEN  value written.
- gpr_snapshot  in  NREG*XLEN  core register file; reg i at bits [i*XLEN +: XLEN].
- trap_valid  in  1  program end/trap signalled.
- trap_code  in  3  trap code; 0 = good trap.
- commit_cnt  out  CNT_W  number of accepted commits.
- cycle_cnt  out  CNT_W  cycles since reset.
- mismatch  out  1  sticky: first divergence detected.
- mismatch_idx  out  5  register index of the first divergence.
- mismatch_pc  out  XLEN  PC of the commit that diverged.
- mismatch_exp  out  XLEN  shadow (expected) value at the divergence.
- mismatch_act  out  XLEN  snapshot (actual) value at the divergence.
- trap_done  out  1  sticky: trap seen.
- trap_good  out  1  trap_done and latched code == 0.
- trap_code_q  out  3  latched trap code.
- last_pc  out  XLEN  PC of the most recent accepted commit.
- last_instr  out  32  instruction word of the most recent accepted commit.

Behaviour:
- Reset: every output is 0, and every shadow register is 0.
- cycle_cnt increments every non-reset cycle and wraps at 2^CNT_W.
- A commit is accepted when commit_valid = 1 and trap_done = 0. Commits arriving after the trap are ignored entirely.
- Accepted commit, next edge:
  - commit_cnt increments by 1.
  - last_pc and last_instr take the commit's values.
- Next-shadow computation (combinational):
  - Equals the shadow, except when commit_wen = 1 and commit_wdest != 0.
  - In that case entry wdest takes commit_wdata, or the snapshot value when commit_skip = 1.
  - Writes to r0 are dropped.
  - The next-shadow registers on the same edge.
- Snapshot timing: gpr_snapshot presented together with a commit already includes that commit's write.
- Compare, only on accepted commits while mismatch = 0:
  - Compare next-shadow against gpr_snapshot for all NREG entries.
  - On any difference, the next edge sets mismatch and latches the lowest differing index, commit_pc, the expected value and the actual value.
- Snapshot r0 != 0 is a mismatch at index 0 with expected value 0.
- The mismatch fields freeze once set. The shadow keeps updating afterwards.
- Trap: the first trap_valid cycle with trap_done = 0 sets trap_done and latches trap_code. Later traps are ignored.
  - A commit and a trap in the same cycle: the commit is accepted first, then the trap latches.
- Reset asserted mid-run clears everything the next edge, including sticky flags.

Decomposition:
- Package difftest_pkg holds XLEN, NREG, CNT_W, TRAP_GOOD = 3'd0 and a register-index typedef.
- Sub-module difftest_shadow_rf contains the shadow register file, the next-value logic and the priority-encoded first-mismatch compare.
- The top handles counters, the accept gating and the trap/mismatch latches.

Test Plan:
- Reset then idle 10 cycles -> cycle_cnt = 10; commit_cnt = 0; mismatch = 0; trap_done = 0.
- Commit pc=0x1c000000, wen, wdest=5, wdata=0xDEADBEEF, snapshot r5 = 0xDEADBEEF -> commit_cnt = 1; mismatch = 0; last_pc = 0x1c000000.
- Same commit but snapshot r5 = 0x12345678 -> mismatch = 1; idx = 5; exp = 0xDEADBEEF; act = 0x12345678; mismatch_pc = 0x1c000000.
- Commit wdest=0, wdata=0xFF with snapshot r0 = 0 -> no mismatch, shadow r0 stays 0.
  - A later snapshot with r0 = 1 -> mismatch; idx = 0.
- Commit with skip=1, wdest=7, wdata=0x1, snapshot r7 = 0x99 -> no mismatch; shadow r7 = 0x99 (a following commit keeping r7 = 0x99 passes).
- trap_valid with code 0 together with a commit -> commit_cnt increments; trap_done = 1; trap_good = 1.
  - A later commit -> commit_cnt unchanged.
  - A later trap with code 1 -> trap_code_q stays 0.

Source files
------------

// File: rtl/difftest_pkg.sv
// Shared constants and types for the difftest commit checker.
package difftest_pkg;

    localparam int XLEN  = 32;              // data / PC / register width
    localparam int NREG  = 32;              // architectural integer registers
    localparam int CNT_W = 64;              // commit and cycle counter width
    localparam int IDX_W = $clog2(NREG);    // register index width

    localparam logic [2:0] TRAP_GOOD = 3'd0;

    typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/difftest_shadow_rf.sv
// Shadow integer register file built from committed writes, with the
// next-value logic and a lowest-index-first compare against the core snapshot.
module difftest_shadow_rf
    import difftest_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,     // accepted commit that writes a GPR
    input  logic                 skip,      // take the value from the snapshot
    input  logic [IDX_W-1:0]     wdest,
    input  logic [XLEN-1:0]      wdata,
    input  logic [NREG*XLEN-1:0] snapshot,
    output logic                 diff,
    output logic [IDX_W-1:0]     diff_idx,
    output logic [XLEN-1:0]      diff_exp,
    output logic [XLEN-1:0]      diff_act
);

    logic [XLEN-1:0] shadow_q [NREG];
    logic [XLEN-1:0] shadow_d [NREG];

    // Next-shadow: hold every entry, then overlay the committed write (r0 never written).
    always_comb begin
        // NOTE: blocking '=' here because later statements must see the
        // defaults; the clocked blocks below use '<=' exclusively.
        for (int i = 0; i < NREG; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (wr_en && (wdest != '0)) begin
            shadow_d[wdest] = skip ? snapshot[int'(wdest)*XLEN +: XLEN] : wdata;
        end
    end

    // Compare next-shadow with the snapshot; scanning downwards lets the lowest index win.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        diff     = 1'b0;
        diff_idx = '0;
        diff_exp = '0;
        diff_act = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (shadow_d[i] != snapshot[i*XLEN +: XLEN]) begin
                diff     = 1'b1;
                diff_idx = IDX_W'(i);
                diff_exp = shadow_d[i];
                diff_act = snapshot[i*XLEN +: XLEN];
            end
        end
    end

    // Shadow storage register.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the whole array is reset so the shadow matches the core's
            // zeroed GPRs; this deliberately keeps it in flops, not a RAM.
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

endmodule

// File: rtl/difftest_commit_checker.sv
// Commit-stream checker: counts commits and cycles, gates commits after the
// trap, and latches the first register divergence and the first trap.
module difftest_commit_checker
    import difftest_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 commit_valid,
    input  logic [XLEN-1:0]      commit_pc,
    input  logic [31:0]          commit_instr,
    input  logic                 commit_skip,
    input  logic                 commit_wen,
    input  logic [4:0]           commit_wdest,
    input  logic [XLEN-1:0]      commit_wdata,
    input  logic [NREG*XLEN-1:0] gpr_snapshot,
    input  logic                 trap_valid,
    input  logic [2:0]           trap_code,
    output logic [CNT_W-1:0]     commit_cnt,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic                 mismatch,
    output logic [4:0]           mismatch_idx,
    output logic [XLEN-1:0]      mismatch_pc,
    output logic [XLEN-1:0]      mismatch_exp,
    output logic [XLEN-1:0]      mismatch_act,
    output logic                 trap_done,
    output logic                 trap_good,
    output logic [2:0]           trap_code_q,
    output logic [XLEN-1:0]      last_pc,
    output logic [31:0]          last_instr
);

    logic            accept;
    logic            diff;
    logic [4:0]      diff_idx;
    logic [XLEN-1:0] diff_exp;
    logic [XLEN-1:0] diff_act;

    // Once the trap is latched the program has ended; later commits are ignored.
    assign accept    = commit_valid && !trap_done;
    assign trap_good = trap_done && (trap_code_q == TRAP_GOOD);

    difftest_shadow_rf u_shadow_rf (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (accept && commit_wen),
        .skip     (commit_skip),
        .wdest    (commit_wdest),
        .wdata    (commit_wdata),
        .snapshot (gpr_snapshot),
        .diff     (diff),
        .diff_idx (diff_idx),
        .diff_exp (diff_exp),
        .diff_act (diff_act)
    );

    // Counters, last-commit record, and the sticky mismatch/trap latches.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt    <= '0;
            commit_cnt   <= '0;
            last_pc      <= '0;
            last_instr   <= '0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
            mismatch_pc  <= '0;
            mismatch_exp <= '0;
            mismatch_act <= '0;
            trap_done    <= 1'b0;
            trap_code_q  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (accept) begin
                commit_cnt <= commit_cnt + 1'b1;
                last_pc    <= commit_pc;
                last_instr <= commit_instr;
                if (!mismatch && diff) begin
                    mismatch     <= 1'b1;
                    mismatch_idx <= diff_idx;
                    mismatch_pc  <= commit_pc;
                    mismatch_exp <= diff_exp;
                    mismatch_act <= diff_act;
                end
            end
            if (trap_valid && !trap_done) begin
                trap_done   <= 1'b1;
                trap_code_q <= trap_code;
            end
        end
    end

endmodule

// File: tb/tb_difftest_commit_checker.sv
// Self-checking bench: directed scenarios plus randomized commit streams,
// compared every cycle against a behavioural model of the checker.
module tb_difftest_commit_checker;
    import difftest_pkg::*;

    logic                 clock;
    logic                 reset;
    logic                 commit_valid;
    logic [XLEN-1:0]      commit_pc;
    logic [31:0]          commit_instr;
    logic                 commit_skip;
    logic                 commit_wen;
    logic [4:0]           commit_wdest;
    logic [XLEN-1:0]      commit_wdata;
    logic [NREG*XLEN-1:0] gpr_snapshot;
    logic                 trap_valid;
    logic [2:0]           trap_code;
    logic [CNT_W-1:0]     commit_cnt;
    logic [CNT_W-1:0]     cycle_cnt;
    logic                 mismatch;
    logic [4:0]           mismatch_idx;
    logic [XLEN-1:0]      mismatch_pc;
    logic [XLEN-1:0]      mismatch_exp;
    logic [XLEN-1:0]      mismatch_act;
    logic                 trap_done;
    logic                 trap_good;
    logic [2:0]           trap_code_q;
    logic [XLEN-1:0]      last_pc;
    logic [31:0]          last_instr;

    difftest_commit_checker dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .commit_skip  (commit_skip),
        .commit_wen   (commit_wen),
        .commit_wdest (commit_wdest),
        .commit_wdata (commit_wdata),
        .gpr_snapshot (gpr_snapshot),
        .trap_valid   (trap_valid),
        .trap_code    (trap_code),
        .commit_cnt   (commit_cnt),
        .cycle_cnt    (cycle_cnt),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx),
        .mismatch_pc  (mismatch_pc),
        .mismatch_exp (mismatch_exp),
        .mismatch_act (mismatch_act),
        .trap_done    (trap_done),
        .trap_good    (trap_good),
        .trap_code_q  (trap_code_q),
        .last_pc      (last_pc),
        .last_instr   (last_instr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: architectural view of what the checker should hold.
    logic [XLEN-1:0]  m_rf [NREG];
    logic [CNT_W-1:0] m_cycle, m_commit;
    logic             m_mis, m_trap;
    logic [4:0]       m_idx;
    logic [XLEN-1:0]  m_pc, m_exp, m_act, m_last_pc;
    logic [31:0]      m_last_instr;
    logic [2:0]       m_code;

    // Snapshot being prepared for the next cycle.
    logic [XLEN-1:0]  snap [NREG];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_snap();
        for (int i = 0; i < NREG; i++) gpr_snapshot[i*XLEN +: XLEN] = snap[i];
    endtask

    // Snapshot that agrees with the model after the pending write is applied.
    task automatic consistent_snap(input logic [XLEN-1:0] skip_val);
        for (int i = 0; i < NREG; i++) snap[i] = m_rf[i];
        if (commit_wen && commit_wdest != 5'd0)
            snap[commit_wdest] = commit_skip ? skip_val : commit_wdata;
        pack_snap();
    endtask

    task automatic apply_model();
        logic [XLEN-1:0] sv [NREG];
        logic acc, found;
        for (int i = 0; i < NREG; i++) sv[i] = gpr_snapshot[i*XLEN +: XLEN];
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            m_cycle = '0; m_commit = '0; m_mis = 1'b0; m_trap = 1'b0;
            m_idx = '0; m_pc = '0; m_exp = '0; m_act = '0;
            m_last_pc = '0; m_last_instr = '0; m_code = '0;
        end else begin
            m_cycle = m_cycle + 1;
            acc = commit_valid && !m_trap;
            if (acc) begin
                m_commit     = m_commit + 1;
                m_last_pc    = commit_pc;
                m_last_instr = commit_instr;
                if (commit_wen && commit_wdest != 5'd0)
                    m_rf[commit_wdest] = commit_skip ? sv[commit_wdest] : commit_wdata;
                if (!m_mis) begin
                    found = 1'b0;
                    for (int i = 0; i < NREG; i++) begin
                        if (!found && m_rf[i] !== sv[i]) begin
                            found = 1'b1;
                            m_mis = 1'b1; m_idx = 5'(i); m_pc = commit_pc;
                            m_exp = m_rf[i]; m_act = sv[i];
                        end
                    end
                end
            end
            if (trap_valid && !m_trap) begin
                m_trap = 1'b1;
                m_code = trap_code;
            end
        end
    endtask

    // Advance one clock: update the model from the inputs, then compare every output.
    task automatic tick();
        apply_model();
        @(posedge clock);
        #1;
        check("cycle_cnt",    cycle_cnt,    m_cycle);
        check("commit_cnt",   commit_cnt,   m_commit);
        check("mismatch",     mismatch,     m_mis);
        check("mismatch_idx", mismatch_idx, m_idx);
        check("mismatch_pc",  mismatch_pc,  m_pc);
        check("mismatch_exp", mismatch_exp, m_exp);
        check("mismatch_act", mismatch_act, m_act);
        check("trap_done",    trap_done,    m_trap);
        check("trap_good",    trap_good,    m_trap && (m_code == 3'd0));
        check("trap_code_q",  trap_code_q,  m_code);
        check("last_pc",      last_pc,      m_last_pc);
        check("last_instr",   last_instr,   m_last_instr);
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0; commit_pc = '0; commit_instr = '0; commit_skip = 1'b0;
        commit_wen = 1'b0; commit_wdest = '0; commit_wdata = '0;
        trap_valid = 1'b0; trap_code = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic commit(input logic [XLEN-1:0] pc, input logic wen, input logic [4:0] wd,
                          input logic [XLEN-1:0] wdata, input logic skip);
        commit_valid = 1'b1; commit_pc = pc; commit_instr = pc ^ 32'h0000_0013;
        commit_wen = wen; commit_wdest = wd; commit_wdata = wdata; commit_skip = skip;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            snap[i] = '0;
            m_rf[i] = '0;
        end
        gpr_snapshot = '0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Reset state, then 10 idle cycles.
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_mismatch", mismatch, 0);
        reset = 1'b0;
        repeat (10) tick();
        check("idle_cycle_cnt", cycle_cnt, 10);
        check("idle_commit_cnt", commit_cnt, 0);
        check("idle_trap_done", trap_done, 0);

        // Matching write to r5.
        commit(32'h1c00_0000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        consistent_snap('0);
        tick();
        check("w5_commit_cnt", commit_cnt, 1);
        check("w5_mismatch", mismatch, 0);
        check("w5_last_pc", last_pc, 32'h1c00_0000);

        // Same commit with a wrong snapshot value in r5.
        snap[5] = 32'h1234_5678;
        pack_snap();
        tick();
        check("d5_mismatch", mismatch, 1);
        check("d5_idx", mismatch_idx, 5);
        check("d5_exp", mismatch_exp, 32'hDEAD_BEEF);
        check("d5_act", mismatch_act, 32'h1234_5678);
        check("d5_pc", mismatch_pc, 32'h1c00_0000);
        idle_inputs();
        tick();

        // Writes to r0 are dropped; a nonzero snapshot r0 diverges at index 0.
        do_reset();
        commit(32'h1c00_0010, 1'b1, 5'd0, 32'h0000_00FF, 1'b0);
        consistent_snap('0);
        tick();
        check("r0w_mismatch", mismatch, 0);
        commit(32'h1c00_0014, 1'b0, 5'd0, 32'h0, 1'b0);
        consistent_snap('0);
        snap[0] = 32'h1;
        pack_snap();
        tick();
        check("r0_mismatch", mismatch, 1);
        check("r0_idx", mismatch_idx, 0);
        check("r0_exp", mismatch_exp, 0);
        check("r0_act", mismatch_act, 1);

        // Skipped commit takes the snapshot value into the shadow.
        do_reset();
        commit(32'h1c00_0020, 1'b1, 5'd7, 32'h1, 1'b1);
        consistent_snap(32'h99);
        tick();
        check("skip_mismatch", mismatch, 0);
        commit(32'h1c00_0024, 1'b0, 5'd0, 32'h0, 1'b0);
        consistent_snap('0);
        tick();
        check("skip_follow_mismatch", mismatch, 0);

        // Trap together with a commit, then later commits/traps are ignored.
        do_reset();
        commit(32'h1c00_0030, 1'b1, 5'd3, 32'h0000_0abc, 1'b0);
        consistent_snap('0);
        trap_valid = 1'b1; trap_code = 3'd0;
        tick();
        check("trap_commit_cnt", commit_cnt, 1);
        check("trap_done", trap_done, 1);
        check("trap_good", trap_good, 1);
        trap_valid = 1'b0;
        commit(32'h1c00_0034, 1'b1, 5'd4, 32'h1, 1'b0);
        consistent_snap('0);
        tick();
        check("post_trap_commit_cnt", commit_cnt, 1);
        check("post_trap_last_pc", last_pc, 32'h1c00_0030);
        idle_inputs();
        trap_valid = 1'b1; trap_code = 3'd1;
        tick();
        check("second_trap_code", trap_code_q, 0);
        // Mid-run reset clears sticky flags.
        do_reset();
        check("reset_trap_done", trap_done, 0);
        check("reset_commit_cnt", commit_cnt, 0);

        // Randomized commit streams with occasional corruption, skips and traps.
        for (int n = 0; n < 600; n++) begin
            if (n % 75 == 0) do_reset();
            commit_valid = ($urandom % 4) != 0;
            commit_pc    = $urandom;
            commit_instr = $urandom;
            commit_wen   = ($urandom % 4) != 0;
            commit_wdest = 5'($urandom % 32);
            commit_wdata = $urandom;
            commit_skip  = ($urandom % 8) == 0;
            consistent_snap($urandom);
            if ($urandom % 25 == 0) begin
                for (int k = 0; k < 1 + int'($urandom % 3); k++) begin
                    int r;
                    r = int'($urandom % 32);
                    snap[r] = snap[r] ^ ($urandom | 32'h1);
                end
                pack_snap();
            end
            trap_valid = ($urandom % 120) == 0;
            trap_code  = 3'($urandom % 8);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
